// File: rtl/fft8_bfly_scheduler.sv
// -----------------------------------------------------------------------------
// fft8_bfly_scheduler
//   Operand/address scheduler for an 8-point radix-2 DIT FFT built around an
//   external butterfly unit. A frame of 8 complex samples is loaded in natural
//   order into a bit-reversed frame buffer. The block then issues three stages
//   of four butterflies each, writes the results back in place, and finally
//   streams the bins X[0]..X[7] out in natural order. The block performs no
//   arithmetic; every data path is a 32-bit pass-through.
//
// Parameters
//   BF_LAT      butterfly latency in cycles (1..4), operands -> results
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input sample handshake, in_data (32b)
//   out_valid/out_ready     output bin handshake, out_data (32b), out_last
//   bf_num1/bf_num2         butterfly operands (upper/lower)
//   bf_twiddle              twiddle index k for result1 (result2 uses k+4)
//   bf_result1/bf_result2   butterfly results, valid BF_LAT cycles after issue
//   busy                    high whenever a frame is being handled
// -----------------------------------------------------------------------------
module fft8_bfly_scheduler #(
    parameter int BF_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [31:0] bf_num1,
    output logic [31:0] bf_num2,
    output logic [2:0]  bf_twiddle,
    input  logic [31:0] bf_result1,
    input  logic [31:0] bf_result2,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    // Last WAIT count: the final write-back of a stage lands on this cycle's edge.
    localparam logic [1:0] WAIT_LAST = 2'(BF_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  in_cnt_q, in_cnt_d;
    logic [1:0]  stage_q, stage_d;
    logic [1:0]  bfly_q, bfly_d;
    logic [1:0]  wait_q, wait_d;
    logic [2:0]  out_cnt_q, out_cnt_d;

    // Write-back delay line: one entry per cycle, tail entry selects the write.
    logic [BF_LAT-1:0] dl_valid_q, dl_valid_d;
    logic [2:0]        dl_a_q [BF_LAT];
    logic [2:0]        dl_a_d [BF_LAT];
    logic [2:0]        dl_b_q [BF_LAT];
    logic [2:0]        dl_b_d [BF_LAT];

    logic [31:0] buf_q [8];
    logic [31:0] buf_d [8];

    logic        issue_s;
    logic        accept_s;
    logic [2:0]  addr_a_s;
    logic [2:0]  addr_b_s;
    logic [2:0]  twiddle_s;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Butterfly addressing and twiddle for the current stage/butterfly index.
    always_comb begin
        addr_a_s  = 3'd0;
        addr_b_s  = 3'd0;
        twiddle_s = 3'd0;
        case (stage_q)
            2'd0: begin
                addr_a_s  = {bfly_q, 1'b0};
                addr_b_s  = {bfly_q, 1'b1};
                twiddle_s = 3'd0;
            end
            2'd1: begin
                addr_a_s  = {bfly_q[1], 1'b0, bfly_q[0]};
                addr_b_s  = {bfly_q[1], 1'b1, bfly_q[0]};
                twiddle_s = {1'b0, bfly_q[0], 1'b0};
            end
            2'd2: begin
                addr_a_s  = {1'b0, bfly_q};
                addr_b_s  = {1'b1, bfly_q};
                twiddle_s = {1'b0, bfly_q};
            end
            default: begin
                addr_a_s  = 3'd0;
                addr_b_s  = 3'd0;
                twiddle_s = 3'd0;
            end
        endcase
    end

    // Next-state, counters, frame-buffer writes and output decode.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        wait_d    = wait_q;
        out_cnt_d = out_cnt_q;
        buf_d     = buf_q;
        issue_s   = 1'b0;

        in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        accept_s  = in_valid && in_ready;

        // Results land exactly BF_LAT cycles after their issue.
        if (dl_valid_q[BF_LAT-1]) begin
            buf_d[dl_a_q[BF_LAT-1]] = bf_result1;
            buf_d[dl_b_q[BF_LAT-1]] = bf_result2;
        end else begin
            buf_d = buf_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    buf_d[bitrev3(3'd0)] = in_data;
                    in_cnt_d = 3'd1;
                    state_d  = ST_LOAD;
                end else begin
                    in_cnt_d = 3'd0;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    buf_d[bitrev3(in_cnt_q)] = in_data;
                    in_cnt_d = in_cnt_q + 3'd1;
                    if (in_cnt_q == 3'd7) begin
                        state_d = ST_ISSUE;
                        stage_d = 2'd0;
                        bfly_d  = 2'd0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                issue_s = 1'b1;
                bfly_d  = bfly_q + 2'd1;
                if (bfly_q == 2'd3) begin
                    state_d = ST_WAIT;
                    wait_d  = 2'd0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    if (stage_q == 2'd2) begin
                        state_d   = ST_UNLOAD;
                        out_cnt_d = 3'd0;
                    end else begin
                        stage_d = stage_q + 2'd1;
                        bfly_d  = 2'd0;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_UNLOAD;
                    end
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid  = (state_q == ST_UNLOAD);
        out_data   = out_valid ? buf_q[out_cnt_q] : 32'd0;
        out_last   = out_valid && (out_cnt_q == 3'd7);
        busy       = (state_q != ST_IDLE);
        bf_num1    = issue_s ? buf_q[addr_a_s] : 32'd0;
        bf_num2    = issue_s ? buf_q[addr_b_s] : 32'd0;
        bf_twiddle = issue_s ? twiddle_s : 3'd0;
    end

    // Shift the write-back delay line; head takes the current issue.
    always_comb begin
        dl_valid_d = dl_valid_q;
        dl_a_d     = dl_a_q;
        dl_b_d     = dl_b_q;
        dl_valid_d[0] = issue_s;
        dl_a_d[0]     = addr_a_s;
        dl_b_d[0]     = addr_b_s;
        for (int i = 1; i < BF_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_a_d[i]     = dl_a_q[i-1];
            dl_b_d[i]     = dl_b_q[i-1];
        end
    end

    // Control state, counters and delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_cnt_q   <= 3'd0;
            stage_q    <= 2'd0;
            bfly_q     <= 2'd0;
            wait_q     <= 2'd0;
            out_cnt_q  <= 3'd0;
            dl_valid_q <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                dl_a_q[i] <= 3'd0;
                dl_b_q[i] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            wait_q     <= wait_d;
            out_cnt_q  <= out_cnt_d;
            dl_valid_q <= dl_valid_d;
            dl_a_q     <= dl_a_d;
            dl_b_q     <= dl_b_d;
        end
    end

    // Frame buffer; contents are meaningless until a frame is loaded.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_fft8_bfly_scheduler.sv
module tb_fft8_bfly_scheduler;

    localparam longint MODP = 65537;

    logic        clk;
    logic        rst_n;
    logic        in_valid   [2];
    logic [31:0] in_data    [2];
    logic        in_ready   [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [31:0] out_data   [2];
    logic        out_last   [2];
    logic [31:0] num1       [2];
    logic [31:0] num2       [2];
    logic [2:0]  tw         [2];
    logic [31:0] res1       [2];
    logic [31:0] res2       [2];
    logic        busy       [2];

    logic [31:0] p_r1 [2][4];
    logic [31:0] p_r2 [2][4];
    longint      wp [8];
    int          total;
    int          bad;

    int br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int tw_tab [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    fft8_bfly_scheduler #(.BF_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .bf_num1(num1[0]), .bf_num2(num2[0]),
        .bf_twiddle(tw[0]), .bf_result1(res1[0]), .bf_result2(res2[0]), .busy(busy[0])
    );

    fft8_bfly_scheduler #(.BF_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .bf_num1(num1[1]), .bf_num2(num2[1]),
        .bf_twiddle(tw[1]), .bf_result1(res1[1]), .bf_result2(res2[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    // Butterfly model in the integers mod 65537, where wp[1] is a primitive
    // 8th root of unity: r = n1 + w^k * n2.
    function automatic logic [31:0] bf_mod(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] k);
        longint t;
        t = (longint'(a) % MODP + wp[k] * (longint'(b) % MODP)) % MODP;
        return 32'(t);
    endfunction

    // Reference DFT of length len over samples x[start + (8/len)*n].
    function automatic logic [31:0] dsub(input logic [31:0] x [8], input int start,
                                         input int len, input int k);
        longint acc;
        int     st;
        st  = 8 / len;
        acc = 0;
        for (int n = 0; n < len; n++)
            acc = (acc + longint'(x[start + st * n]) * wp[(st * n * k) % 8]) % MODP;
        return 32'(acc);
    endfunction

    function automatic longint mpow(input longint b, input int e);
        longint r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % MODP;
        return r;
    endfunction

    // Butterfly pipelines: instance 0 reads stage 0, instance 1 reads stage 2.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 3; i > 0; i--) begin
                p_r1[u][i] <= p_r1[u][i-1];
                p_r2[u][i] <= p_r2[u][i-1];
            end
            p_r1[u][0] <= bf_mod(num1[u], num2[u], tw[u]);
            p_r2[u][0] <= bf_mod(num1[u], num2[u], tw[u] + 3'd4);
        end
    end

    assign res1[0] = p_r1[0][0];
    assign res2[0] = p_r2[0][0];
    assign res1[1] = p_r1[1][2];
    assign res2[1] = p_r2[1][2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset(input int u);
        chk("rst_in_ready", 64'(in_ready[u]), 64'd1);
        chk("rst_out_valid", 64'(out_valid[u]), 64'd0);
        chk("rst_out_last", 64'(out_last[u]), 64'd0);
        chk("rst_busy", 64'(busy[u]), 64'd0);
        chk("rst_bf_num1", 64'(num1[u]), 64'd0);
        chk("rst_bf_num2", 64'(num2[u]), 64'd0);
        chk("rst_bf_twiddle", 64'(tw[u]), 64'd0);
    endtask

    task automatic rand_frame(output logic [31:0] x [8]);
        for (int n = 0; n < 8; n++) x[n] = 32'($urandom_range(0, 65536));
    endtask

    task automatic send(input int u, input logic [31:0] x [8]);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                in_valid[u] = 1'b0;
                @(negedge clk);
            end
            in_valid[u] = 1'b1;
            in_data[u]  = x[n];
            chk("in_ready_load", 64'(in_ready[u]), 64'd1);
            @(posedge clk);
        end
    endtask

    // Issue trace and frame latency, timed from the last input beat.
    task automatic trace(input int u, input int lat, input logic [31:0] x [8]);
        int per;
        int st;
        int pos;
        per = 4 + lat;
        for (int c = 0; c < 3 * per; c++) begin
            @(negedge clk);
            in_valid[u] = (c < 8);
            in_data[u]  = $urandom;
            st  = c / per;
            pos = c % per;
            chk("in_ready_busy", 64'(in_ready[u]), 64'd0);
            chk("busy_frame", 64'(busy[u]), 64'd1);
            chk("out_valid_early", 64'(out_valid[u]), 64'd0);
            if (pos < 4) begin
                chk("twiddle", 64'(tw[u]), 64'(tw_tab[st][pos]));
                if (st == 0) begin
                    chk("s0_num1", 64'(num1[u]), 64'(x[br_tab[2 * pos]]));
                    chk("s0_num2", 64'(num2[u]), 64'(x[br_tab[2 * pos + 1]]));
                end
                if (st == 2) begin
                    chk("s2_num1", 64'(num1[u]), 64'(dsub(x, 0, 4, pos)));
                    chk("s2_num2", 64'(num2[u]), 64'(dsub(x, 1, 4, pos)));
                end
            end else begin
                chk("idle_num1", 64'(num1[u]), 64'd0);
                chk("idle_num2", 64'(num2[u]), 64'd0);
                chk("idle_twiddle", 64'(tw[u]), 64'd0);
            end
        end
        @(negedge clk);
        in_valid[u] = 1'b0;
        chk("latency_out_valid", 64'(out_valid[u]), 64'd1);
    endtask

    task automatic collect(input int u, input logic [31:0] exp_x [8], input bit rnd);
        int k;
        int guard;
        bit rdy;
        k = 0;
        guard = 0;
        while (k < 8 && guard < 200) begin
            rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            out_ready[u] = rdy;
            chk("out_valid", 64'(out_valid[u]), 64'd1);
            chk("out_data", 64'(out_data[u]), 64'(exp_x[k]));
            chk("out_last", 64'(out_last[u]), 64'(k == 7));
            @(posedge clk);
            if (rdy) k++;
            @(negedge clk);
            guard++;
        end
        out_ready[u] = 1'b0;
        chk("collect_count", 64'(k), 64'd8);
        chk("post_in_ready", 64'(in_ready[u]), 64'd1);
        chk("post_busy", 64'(busy[u]), 64'd0);
        chk("post_out_valid", 64'(out_valid[u]), 64'd0);
    endtask

    task automatic full_frame(input int u, input int lat, input logic [31:0] x [8],
                              input bit rnd);
        logic [31:0] ex [8];
        for (int k = 0; k < 8; k++) ex[k] = dsub(x, 0, 8, k);
        send(u, x);
        trace(u, lat, x);
        collect(u, ex, rnd);
    endtask

    initial begin
        logic [31:0] x [8];
        clk   = 1'b0;
        rst_n = 1'b0;
        total = 0;
        bad   = 0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = 32'd0;
            out_ready[u] = 1'b0;
        end
        for (int k = 0; k < 8; k++) wp[k] = mpow(mpow(64'd3, 8192), k);
        #1;
        chk_reset(0);
        chk_reset(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // BF_LAT=1: random frame, then impulse (every bin 1)
        rand_frame(x);
        full_frame(0, 1, x, 1'b0);
        for (int n = 0; n < 8; n++) x[n] = (n == 0) ? 32'd1 : 32'd0;
        full_frame(0, 1, x, 1'b1);

        // BF_LAT=3: random frames with a randomly stalling consumer
        rand_frame(x);
        full_frame(1, 3, x, 1'b1);
        rand_frame(x);
        full_frame(1, 3, x, 1'b1);

        // Reset pulsed during stage 1, then a clean frame
        rand_frame(x);
        send(0, x);
        repeat (7) begin
            @(negedge clk);
            in_valid[0] = 1'b0;
        end
        chk("pre_rst_busy", 64'(busy[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0);
        rand_frame(x);
        full_frame(0, 1, x, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
